layer_out_sequencer: RTL and testbench

- Sits between a layer's neuron array and the next layer's single serial input.
- Captures the NN parallel neuron outputs when the whole layer reports valid.
- Replays the captured values one element per accepted beat, index 0 first, with valid/ready flow control.
- Reports busy and overrun status so the top-level scheduler can pace input frames.

---
 rtl/layer_out_sequencer.sv | 130 +++++++++++++
 tb/tb_layer_out_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_sequencer.sv
// Captures a full layer of neuron outputs and replays them one element per accepted beat.
// Optional argmax tracking over each replayed frame is enabled by defining LAYER_ARGMAX_EN.
module layer_out_sequencer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16,
  parameter int IDXW      = $clog2(NN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  output logic [IDXW-1:0]         out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun,
  output logic                    partial_err,
`ifdef LAYER_ARGMAX_EN
  output logic                    max_valid,
  output logic [IDXW-1:0]         max_idx,
  output logic [dataWidth-1:0]    max_val,
`endif
  output logic [15:0]             frame_cnt
);

  localparam int unsigned LAST_IDX = NN - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [dataWidth-1:0] cap [NN];

  logic            frame_ok_c;
  logic            partial_c;
  logic            xfer_c;
  logic            at_last_c;
  logic [IDXW-1:0] nxt_idx_c;

  assign frame_ok_c = &in_valid;
  assign partial_c  = (|in_valid) && !frame_ok_c;
  assign xfer_c     = out_valid && out_ready;
  assign at_last_c  = (out_idx == IDXW'(LAST_IDX));
  assign nxt_idx_c  = out_idx + IDXW'(1);

  // Capture / replay FSM; out_idx doubles as the replay pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      partial_err <= 1'b0;
      frame_cnt   <= '0;
      for (int i = 0; i < NN; i++) cap[i] <= '0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_ok_c) begin
            for (int i = 0; i < NN; i++) cap[i] <= in_data[i*dataWidth +: dataWidth];
            out_data  <= in_data[0 +: dataWidth];
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SHIFT;
          end else if (partial_c) begin
            partial_err <= 1'b1;
          end
        end
        SHIFT: begin
          // Any full frame seen while replaying is dropped, including on the last beat.
          overrun <= frame_ok_c;
          if (xfer_c) begin
            if (at_last_c) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_last  <= 1'b0;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              out_idx  <= nxt_idx_c;
              out_data <= cap[nxt_idx_c];
              out_last <= (nxt_idx_c == IDXW'(LAST_IDX));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LAYER_ARGMAX_EN
  logic [dataWidth-1:0] run_val;
  logic [IDXW-1:0]      run_idx;
  logic                 take_c;

  // Element 0 seeds the maximum; strict greater-than keeps the lowest index on ties.
  assign take_c = (out_idx == '0) || ($signed(out_data) > $signed(run_val));

  always_ff @(posedge clk) begin
    if (rst) begin
      run_val   <= '0;
      run_idx   <= '0;
      max_valid <= 1'b0;
      max_idx   <= '0;
      max_val   <= '0;
    end else begin
      max_valid <= 1'b0;
      if (state == SHIFT && xfer_c) begin
        if (take_c) begin
          run_val <= out_data;
          run_idx <= out_idx;
        end
        if (at_last_c) begin
          max_valid <= 1'b1;
          max_val   <= take_c ? out_data : run_val;
          max_idx   <= take_c ? out_idx  : run_idx;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_out_sequencer.sv
// Self-checking bench for layer_out_sequencer: vector table, directed corner sequences and a
// randomized run against a queue-based reference model. Argmax checks follow LAYER_ARGMAX_EN.
module tb_layer_out_sequencer;

  localparam int NN   = 10;
  localparam int DW   = 16;
  localparam int IDXW = $clog2(NN);

  logic                 clk;
  logic                 rst;
  logic [NN-1:0]        in_valid;
  logic [NN*DW-1:0]     in_data;
  logic                 out_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [IDXW-1:0]      out_idx;
  logic                 out_last;
  logic                 busy;
  logic                 overrun;
  logic                 partial_err;
  logic [15:0]          frame_cnt;
`ifdef LAYER_ARGMAX_EN
  logic                 max_valid;
  logic [IDXW-1:0]      max_idx;
  logic [DW-1:0]        max_val;
`endif

  layer_out_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .overrun(overrun), .partial_err(partial_err),
`ifdef LAYER_ARGMAX_EN
    .max_valid(max_valid), .max_idx(max_idx), .max_val(max_val),
`endif
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [NN-1:0] ALL = {NN{1'b1}};

  typedef struct {
    logic [NN-1:0] iv;
    logic          rdy;
    logic          ev;
    logic [15:0]   ed;
    logic [3:0]    ei;
    logic          el;
    logic          eo;
    logic [15:0]   ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [NN-1:0] iv, logic rdy, logic ev, logic [15:0] ed,
                              int ei, logic el, logic eo, logic [15:0] ecnt);
    vec_t v;
    v.iv = iv; v.rdy = rdy; v.ev = ev; v.ed = ed; v.ei = 4'(ei);
    v.el = el; v.eo = eo; v.ecnt = ecnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [15:0] base);
    for (int i = 0; i < NN; i++) in_data[i*DW +: DW] = base + 16'(i);
  endtask

  // Reference model: a queue of pending elements plus the last captured frame.
  logic [15:0] mq[$];
  logic [15:0] mf[NN];
  logic [15:0] m_cnt;
  logic        m_perr, m_ovr, m_mv;
  logic [3:0]  m_mi;
  logic [15:0] m_mval;

  function automatic void model_step(logic [NN-1:0] iv, logic [NN*DW-1:0] din, logic rdy);
    bit active;
    int bi;
    active = (mq.size() > 0);
    m_ovr  = active && (iv == ALL);
    m_mv   = 1'b0;
    if (!active && iv != '0 && iv != ALL) m_perr = 1'b1;
    if (active && rdy) begin
      void'(mq.pop_front());
      if (mq.size() == 0) begin
        m_cnt = m_cnt + 16'd1;
        bi = 0;
        for (int i = 1; i < NN; i++) if ($signed(mf[i]) > $signed(mf[bi])) bi = i;
        m_mv = 1'b1; m_mi = 4'(bi); m_mval = mf[bi];
      end
    end else if (!active && iv == ALL) begin
      for (int i = 0; i < NN; i++) begin
        mf[i] = din[i*DW +: DW];
        mq.push_back(mf[i]);
      end
    end
  endfunction

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_perr", 32'(partial_err), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    chk("rst_last", 32'(out_last), 0);
    rst = 1'b0;

    // Frame at full rate, then the same frame with a 3-cycle stall at idx 4.
    add(ALL, 1, 1, 16'h10, 0, 0, 0, 0);
    for (int k = 1; k < NN; k++) add('0, 1, 1, 16'(16'h10 + k), k, k == NN-1, 0, 0);
    add('0, 1, 0, 0, 0, 0, 0, 1);
    add(ALL, 1, 1, 16'h10, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) add('0, 1, 1, 16'(16'h10 + k), k, 0, 0, 1);
    for (int k = 0; k < 3; k++) add('0, 0, 1, 16'h14, 4, 0, 0, 1);
    for (int k = 5; k < NN; k++) add('0, 1, 1, 16'(16'h10 + k), k, k == NN-1, 0, 1);
    add('0, 1, 0, 0, 0, 0, 0, 2);

    set_frame(16'h10);
    for (int r = 0; r < tbl.size(); r++) begin
      in_valid = tbl[r].iv; out_ready = tbl[r].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_ovr", r), 32'(overrun), 32'(tbl[r].eo));
      chk($sformatf("tbl%0d_cnt", r), 32'(frame_cnt), 32'(tbl[r].ecnt));
      chk($sformatf("tbl%0d_last", r), 32'(out_last), 32'(tbl[r].el));
      if (tbl[r].ev) begin
        chk($sformatf("tbl%0d_data", r), 32'(out_data), 32'(tbl[r].ed));
        chk($sformatf("tbl%0d_idx", r), 32'(out_idx), 32'(tbl[r].ei));
      end
    end
    in_valid = '0;

    // Overrun mid-frame while stalled: captured data must be untouched.
    in_valid = ALL; out_ready = 1'b1;
    tick();
    in_valid = '0;
    repeat (5) tick();
    chk("ovr_pre_idx", 32'(out_idx), 5);
    set_frame(16'h100); in_valid = ALL; out_ready = 1'b0;
    tick();
    chk("ovr_pulse", 32'(overrun), 1);
    chk("ovr_hold_idx", 32'(out_idx), 5);
    chk("ovr_hold_data", 32'(out_data), 32'h15);
    set_frame(16'h10); in_valid = '0; out_ready = 1'b1;
    tick();
    chk("ovr_one_cycle", 32'(overrun), 0);
    chk("ovr_data6", 32'(out_data), 32'h16);
    for (int k = 7; k < NN; k++) begin
      tick();
      chk($sformatf("ovr_data%0d", k), 32'(out_data), 32'(16'h10 + k));
    end
    // Full frame on the last transfer is dropped; the next one is accepted.
    in_valid = ALL;
    tick();
    chk("lastovr_valid", 32'(out_valid), 0);
    chk("lastovr_pulse", 32'(overrun), 1);
    chk("lastovr_cnt", 32'(frame_cnt), 3);
    tick();
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_idx", 32'(out_idx), 0);
    chk("b2b_ovr", 32'(overrun), 0);
    in_valid = '0;
    repeat (NN) tick();
    chk("b2b_cnt", 32'(frame_cnt), 4);
    chk("b2b_done", 32'(out_valid), 0);

    // Partial valid in idle: sticky error, no output, full frame still works.
    in_valid = 10'h00F;
    tick();
    chk("part_err", 32'(partial_err), 1);
    chk("part_novalid", 32'(out_valid), 0);
    in_valid = '0;
    tick();
    chk("part_sticky", 32'(partial_err), 1);
    chk("part_novalid2", 32'(out_valid), 0);
    in_valid = ALL;
    tick();
    chk("part_then_frame", 32'(out_valid), 1);
    in_valid = '0;
    repeat (6) tick();
    chk("rstmid_idx", 32'(out_idx), 6);

    // Reset mid-frame discards the frame.
    rst = 1'b1;
    tick();
    chk("rstmid_valid", 32'(out_valid), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_perr", 32'(partial_err), 0);
    chk("rstmid_last", 32'(out_last), 0);
    chk("rstmid_cnt", 32'(frame_cnt), 0);
    rst = 1'b0; in_valid = ALL;
    tick();
    chk("rstmid_restart", 32'(out_valid), 1);
    chk("rstmid_idx0", 32'(out_idx), 0);
    chk("rstmid_data0", 32'(out_data), 32'h10);
    in_valid = '0;
    repeat (NN) tick();
    chk("rstmid_cnt1", 32'(frame_cnt), 1);

`ifdef LAYER_ARGMAX_EN
    in_data = '0;
    in_data[0*DW +: DW] = 16'hFFFD;
    in_data[1*DW +: DW] = 16'h0007;
    in_data[2*DW +: DW] = 16'h0002;
    in_data[3*DW +: DW] = 16'h0007;
    in_valid = ALL;
    tick();
    in_valid = '0;
    repeat (NN-1) tick();
    chk("amax_early", 32'(max_valid), 0);
    tick();
    chk("amax_valid", 32'(max_valid), 1);
    chk("amax_idx", 32'(max_idx), 1);
    chk("amax_val", 32'(max_val), 32'h7);
    tick();
    chk("amax_pulse", 32'(max_valid), 0);
    chk("amax_hold", 32'(max_idx), 1);
`endif

    // Randomized run against the reference model.
    rst = 1'b1; in_valid = '0;
    tick();
    rst = 1'b0;
    mq.delete(); m_cnt = '0; m_perr = 1'b0; m_ovr = 1'b0; m_mv = 1'b0;
    m_mi = '0; m_mval = '0;
    for (int i = 0; i < NN; i++) mf[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) in_valid = ALL;
      else if (r < 10) in_valid = NN'($urandom_range(1, (1 << NN) - 2));
      else in_valid = '0;
      for (int i = 0; i < NN; i++) in_data[i*DW +: DW] = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      model_step(in_valid, in_data, out_ready);
      tick();
      chk("rnd_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("rnd_busy", 32'(busy), 32'(mq.size() > 0));
      chk("rnd_ovr", 32'(overrun), 32'(m_ovr));
      chk("rnd_perr", 32'(partial_err), 32'(m_perr));
      chk("rnd_cnt", 32'(frame_cnt), 32'(m_cnt));
      if (mq.size() > 0) begin
        chk("rnd_data", 32'(out_data), 32'(mq[0]));
        chk("rnd_idx", 32'(out_idx), 32'(NN - mq.size()));
        chk("rnd_last", 32'(out_last), 32'(mq.size() == 1));
      end
`ifdef LAYER_ARGMAX_EN
      chk("rnd_mvalid", 32'(max_valid), 32'(m_mv));
      if (m_cnt != 0) begin
        chk("rnd_midx", 32'(max_idx), 32'(m_mi));
        chk("rnd_mval", 32'(max_val), 32'(m_mval));
      end
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
